// File: rtl/tri_mon_pkg.sv
// Shared encodings for the triangle-wave monitor: phase codes and sample-step classes.
// Latency: n/a (constants only).
// Backpressure: n/a (no flow control in this block).
package tri_pkg;

  // Phase encoding, also driven on the phase output.
  localparam logic [2:0] PH_SYNC = 3'd0;
  localparam logic [2:0] PH_RISE = 3'd1;
  localparam logic [2:0] PH_HIGH = 3'd2;
  localparam logic [2:0] PH_FALL = 3'd3;
  localparam logic [2:0] PH_LOW  = 3'd4;

  // Step classes for d_in relative to d_prev.
  localparam logic [1:0] DC_UP   = 2'd0;
  localparam logic [1:0] DC_FLAT = 2'd1;
  localparam logic [1:0] DC_DOWN = 2'd2;
  localparam logic [1:0] DC_BAD  = 2'd3;

endpackage

// File: rtl/tri_mon_if.sv
// Monitor bus: sample input plus all measurement/status outputs of tri_mon.
// Latency: n/a (wiring only).
// Backpressure: none; a sample is valid every clock.
// Ports: d_in (sample), phase, lock, period_done, err, err_cnt, peak,
//        rise_len/high_len/fall_len/low_len, period.
interface tri_mon_if #(
  parameter int DW  = 10,
  parameter int CW  = 12,
  parameter int ECW = 8
) ();
  logic [DW-1:0]  d_in;
  logic [2:0]     phase;
  logic           lock;
  logic           period_done;
  logic           err;
  logic [ECW-1:0] err_cnt;
  logic [DW-1:0]  peak;
  logic [CW-1:0]  rise_len;
  logic [CW-1:0]  high_len;
  logic [CW-1:0]  fall_len;
  logic [CW-1:0]  low_len;
  logic [CW+1:0]  period;

  // Source side: drives samples, observes the measurements.
  modport master (
    output d_in,
    input  phase, lock, period_done, err, err_cnt, peak,
           rise_len, high_len, fall_len, low_len, period
  );

  // Monitor side.
  modport slave (
    input  d_in,
    output phase, lock, period_done, err, err_cnt, peak,
           rise_len, high_len, fall_len, low_len, period
  );
endinterface

// File: rtl/tri_mon_delta_cls.sv
// Classifies one sample step d_in vs d_prev as UP(+1)/FLAT/DOWN(-1)/BAD.
// Latency: combinational.
// Backpressure: none.
// Ports: i_d_in, i_d_prev (samples), o_cls (2-bit class code from tri_pkg).
module tri_delta_cls
  import tri_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic [DW-1:0] i_d_in,
  input  logic [DW-1:0] i_d_prev,
  output logic [1:0]    o_cls
);

  logic [DW-1:0] w_up_diff;
  logic [DW-1:0] w_dn_diff;

  // Differences are only meaningful when taken from the larger operand, so a
  // wrap such as all-ones -> 0 never classifies as a single step.
  assign w_up_diff = i_d_in - i_d_prev;
  assign w_dn_diff = i_d_prev - i_d_in;

  always_comb begin
    o_cls = DC_BAD;
    if (i_d_in == i_d_prev) begin
      o_cls = DC_FLAT;
    end else if ((i_d_in > i_d_prev) && (w_up_diff == DW'(1))) begin
      o_cls = DC_UP;
    end else if ((i_d_prev > i_d_in) && (w_dn_diff == DW'(1))) begin
      o_cls = DC_DOWN;
    end
  end

endmodule

// File: rtl/tri_mon.sv
// Triangle-stream monitor: tracks rise/high/fall/low phases, measures lengths, peak, period, flags shape errors.
// Latency: all outputs registered; effects of a deciding sample appear one clock after it is sampled.
// Backpressure: none; one sample accepted every clock.
// Ports: clk, res (sync active-high), bus (tri_mon_if.slave: d_in in, measurements out).
module tri_mon
  import tri_pkg::*;
#(
  parameter int DW      = 10,
  parameter int CW      = 12,
  parameter int MIN_LVL = 0,
  parameter int ECW     = 8
) (
  input  logic        clk,
  input  logic        res,
  tri_mon_if.slave    bus
);

  localparam logic [DW-1:0] LVL_MIN = DW'(MIN_LVL);

  logic [DW-1:0]  r_d_prev;
  logic           r_prev_vld;
  logic [2:0]     r_phase;
  logic [CW-1:0]  r_cnt;
  logic           r_lock;
  logic           r_period_done;
  logic           r_err;
  logic [ECW-1:0] r_err_cnt;
  logic [DW-1:0]  r_peak;
  logic [CW-1:0]  r_rise_len;
  logic [CW-1:0]  r_high_len;
  logic [CW-1:0]  r_fall_len;
  logic [CW-1:0]  r_low_len;
  logic [CW+1:0]  r_period;

  logic [1:0]     w_cls;
  logic           w_viol;
  logic [CW-1:0]  w_cnt_inc;
  logic [ECW-1:0] w_err_inc;
  logic [CW+1:0]  w_period;

  tri_delta_cls #(.DW(DW)) u_cls (
    .i_d_in   (bus.d_in),
    .i_d_prev (r_d_prev),
    .o_cls    (w_cls)
  );

  // Both counters stick at all-ones instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_err_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ECW'(1);

  // Low length is still in r_cnt at the LOW->RISE edge, so it is summed live.
  assign w_period = (CW+2)'(r_rise_len) + (CW+2)'(r_high_len)
                  + (CW+2)'(r_fall_len) + (CW+2)'(r_cnt);

  // Shape violation for the current phase; SYNC never flags.
  always_comb begin
    w_viol = 1'b0;
    if (r_prev_vld) begin
      case (r_phase)
        PH_RISE: w_viol = (w_cls == DC_DOWN) || (w_cls == DC_BAD);
        PH_HIGH: w_viol = (w_cls == DC_UP)   || (w_cls == DC_BAD);
        PH_FALL: w_viol = !((w_cls == DC_DOWN) ||
                            ((w_cls == DC_FLAT) && (bus.d_in == LVL_MIN)));
        PH_LOW:  w_viol = (w_cls == DC_DOWN) || (w_cls == DC_BAD);
        default: w_viol = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_d_prev      <= '0;
      r_prev_vld    <= 1'b0;
      r_phase       <= PH_SYNC;
      r_cnt         <= '0;
      r_lock        <= 1'b0;
      r_period_done <= 1'b0;
      r_err         <= 1'b0;
      r_err_cnt     <= '0;
      r_peak        <= '0;
      r_rise_len    <= '0;
      r_high_len    <= '0;
      r_fall_len    <= '0;
      r_low_len     <= '0;
      r_period      <= '0;
    end else begin
      r_d_prev      <= bus.d_in;
      r_prev_vld    <= 1'b1;
      r_period_done <= 1'b0;
      r_err         <= 1'b0;

      if (w_viol) begin
        // Lengths and peak deliberately keep their last good values.
        r_err     <= 1'b1;
        r_err_cnt <= w_err_inc;
        r_lock    <= 1'b0;
        r_phase   <= PH_SYNC;
      end else if (r_prev_vld) begin
        case (r_phase)
          PH_SYNC: begin
            // Only a step up off the bottom gives a trustworthy period start.
            if ((w_cls == DC_UP) && (r_d_prev == LVL_MIN)) begin
              r_phase <= PH_RISE;
              r_cnt   <= CW'(1);
            end
          end
          PH_RISE: begin
            if (w_cls == DC_UP) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_rise_len <= r_cnt;
              r_peak     <= bus.d_in;
              r_phase    <= PH_HIGH;
              r_cnt      <= CW'(1);
            end
          end
          PH_HIGH: begin
            if (w_cls == DC_FLAT) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_high_len <= r_cnt;
              r_phase    <= PH_FALL;
              r_cnt      <= CW'(1);
            end
          end
          PH_FALL: begin
            if (w_cls == DC_DOWN) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_fall_len <= r_cnt;
              r_phase    <= PH_LOW;
              r_cnt      <= CW'(1);
            end
          end
          PH_LOW: begin
            if (w_cls == DC_FLAT) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_low_len     <= r_cnt;
              r_period      <= w_period;
              r_period_done <= 1'b1;
              r_lock        <= 1'b1;
              r_phase       <= PH_RISE;
              r_cnt         <= CW'(1);
            end
          end
          default: begin
            r_phase <= PH_SYNC;
          end
        endcase
      end
    end
  end

  assign bus.phase       = r_phase;
  assign bus.lock        = r_lock;
  assign bus.period_done = r_period_done;
  assign bus.err         = r_err;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.peak        = r_peak;
  assign bus.rise_len    = r_rise_len;
  assign bus.high_len    = r_high_len;
  assign bus.fall_len    = r_fall_len;
  assign bus.low_len     = r_low_len;
  assign bus.period      = r_period;

endmodule
